// File: rtl/enoc_network_interface.sv
// Core-side network interface: injection and ejection FWFT queues between a
// processing node and router port 0, with saturating traffic counters and a sticky misroute flag.

package enoc_pkg;
    localparam int unsigned NODES     = 16;
    localparam int unsigned DEST_W    = $clog2(NODES);
    localparam int unsigned PAYLOAD_W = 12;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;
endpackage

// First-word-fall-through queue with enable/valid handshakes on both sides.
module enoc_ni_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  enoc_pkg::packet_t      i_data,
    input  logic                   i_val,
    output logic                   o_en,
    output enoc_pkg::packet_t      o_data,
    output logic                   o_val,
    input  logic                   i_en,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    enoc_pkg::packet_t r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_count;
    logic              w_has_room;
    logic              w_push;
    logic              w_pop;

    // Acceptance looks only at the registered count, never at the pop side.
    assign w_has_room = (r_count < FULL);
    assign o_en       = reset_n && w_has_room;
    assign o_val      = (r_count != '0);
    assign o_data     = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign w_push     = i_val && w_has_room;
    assign w_pop      = o_val && i_en;

    // Storage is not reset; clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: ;
            endcase
        end
    end
endmodule

module enoc_network_interface #(
    parameter int unsigned NODES     = 16,
    parameter int unsigned LOC       = 0,
    parameter int unsigned INJ_DEPTH = 4,
    parameter int unsigned EJ_DEPTH  = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  enoc_pkg::packet_t          i_inj_data,
    input  logic                       i_inj_val,
    output logic                       o_inj_en,
    output enoc_pkg::packet_t          o_net_data,
    output logic                       o_net_val,
    input  logic                       i_net_en,
    input  enoc_pkg::packet_t          i_net_data,
    input  logic                       i_net_val,
    output logic                       o_net_en,
    output enoc_pkg::packet_t          o_ej_data,
    output logic                       o_ej_val,
    input  logic                       i_ej_en,
    output logic [$clog2(INJ_DEPTH):0] o_inj_occupancy,
    output logic [CNT_W-1:0]           o_inj_count,
    output logic [CNT_W-1:0]           o_ej_count,
    output logic                       o_misroute
);
    localparam int unsigned DEST_W    = $clog2(NODES);
    localparam int unsigned EJ_OCC_W  = $clog2(EJ_DEPTH) + 1;
    localparam logic [DEST_W-1:0]   LOC_ADDR = DEST_W'(LOC);
    localparam logic [EJ_OCC_W-1:0] EJ_FULL  = EJ_OCC_W'(EJ_DEPTH);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    logic [EJ_OCC_W-1:0] w_ej_occ;
    logic                w_inj_pop;
    logic                w_ej_push;
    logic                w_ej_pop;
    logic [CNT_W-1:0]    r_inj_count;
    logic [CNT_W-1:0]    r_ej_count;
    logic                r_misroute;

    enoc_ni_fifo #(.DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (i_inj_data),
        .i_val   (i_inj_val),
        .o_en    (o_inj_en),
        .o_data  (o_net_data),
        .o_val   (o_net_val),
        .i_en    (i_net_en),
        .o_count (o_inj_occupancy)
    );

    enoc_ni_fifo #(.DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (i_net_data),
        .i_val   (i_net_val),
        .o_en    (o_net_en),
        .o_data  (o_ej_data),
        .o_val   (o_ej_val),
        .i_en    (i_ej_en),
        .o_count (w_ej_occ)
    );

    assign w_inj_pop = o_net_val && i_net_en;
    assign w_ej_pop  = o_ej_val && i_ej_en;
    assign w_ej_push = i_net_val && (w_ej_occ < EJ_FULL);

    // Saturating delivery counters and sticky wrong-destination flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inj_count <= '0;
            r_ej_count  <= '0;
            r_misroute  <= 1'b0;
        end else begin
            if (w_inj_pop && (r_inj_count != CNT_MAX)) begin
                r_inj_count <= r_inj_count + CNT_W'(1);
            end
            if (w_ej_pop && (r_ej_count != CNT_MAX)) begin
                r_ej_count <= r_ej_count + CNT_W'(1);
            end
            if (w_ej_push && (i_net_data.dest != LOC_ADDR)) begin
                r_misroute <= 1'b1;
            end
        end
    end

    assign o_inj_count = r_inj_count;
    assign o_ej_count  = r_ej_count;
    assign o_misroute  = r_misroute;
endmodule
